deser_input_arbiter: RTL and testbench
======================================

Name: deser_input_arbiter

Overview:
- Shares the single bit-serial deserializer between N_SRC serial sources. Grants one source at a time for exactly one byte (BITS_PER_WORD write strobes).
- Muxes the owner's data/write onto the deserializer inputs and tags the finished byte with the owner's source id for the downstream queue.
- Holds the next grant until the queue acknowledges the byte.
- Sits between the serial sources and the deserializer, in the clock_100KHZ domain.

Parameters:
N_SRC, 4, number of serial requesters (2..8)
BITS_PER_WORD, 8, write strobes forwarded per grant
STALL_LIMIT, 255, max cycles between owner writes before stall_err_out is set
ID_W, $clog2(N_SRC), width of the source id

Ports:
clock_100KHZ  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_in  in  N_SRC  source i requests a byte slot (level)
src_data_in  in  N_SRC  serial data bit per source
src_write_in  in  N_SRC  bit strobe per source
grant_out  out  N_SRC  one-hot grant, registered
deser_status_in  in  1  deserializer status_out (1 = can accept bits)
deser_ready_in  in  1  deserializer data_ready
ack_in  in  1  queue ack (same wire that drives the deserializer ack_in)
deser_data_out  out  1  muxed data bit to the deserializer data_in
deser_write_out  out  1  muxed strobe to the deserializer write_in
src_id_out  out  ID_W  id of the owner of the current or last byte
tag_valid_out  out  1  src_id_out qualifies the byte currently presented by the deserializer
busy_out  out  1  arbiter not in IDLE
stall_err_out  out  1  sticky stall flag

Behaviour:
- Reset: reset is asynchronous and active-high; clock is clock_100KHZ. All outputs are 0 at reset. State = IDLE, rr pointer = 0, bit count = 0.
- FSM states: IDLE, SHIFT, DRAIN, WAIT_ACK.
- IDLE:
  - Grant when deser_status_in=1 and |req_in=1.
  - Round-robin pick: first requester at or after the rr pointer, wrapping modulo N_SRC.
  - Next cycle: grant_out = onehot(pick), src_id_out = pick, state = SHIFT. Grant latency is 1 cycle from the sampled request.
  - No grant while deser_status_in=0.
- SHIFT:
  - Combinational forwarding: deser_write_out = src_write_in[owner] & deser_status_in; deser_data_out = src_data_in[owner].
  - Strobes from non-owners are ignored; deser_data_out = 0 when no write is forwarded.
  - Bit count increments on each forwarded write. On the write where count = BITS_PER_WORD-1: grant_out -> 0 next cycle, count -> 0, state = DRAIN.
  - Writes after that are never forwarded.
  - req_in is only sampled in IDLE. If the owner drops req mid-byte, the grant is held until the byte completes.
- Stall detection:
  - The stall counter counts cycles in SHIFT with no owner write and clears on each write.
  - At STALL_LIMIT, stall_err_out is set (sticky until reset). The grant is kept; no abort, because the deserializer has no partial-byte flush.
- DRAIN: wait for deser_ready_in=1, then tag_valid_out=1 and state = WAIT_ACK.
- WAIT_ACK:
  - On ack_in=1: tag_valid_out -> 0, rr pointer = (owner+1) mod N_SRC, state = IDLE.
  - src_id_out holds its value until the next grant.
- ack_in outside WAIT_ACK is ignored.
- Simultaneous events:
  - ack_in and a new request in the same cycle: the request is evaluated next cycle, in IDLE, against the updated pointer.
  - deser_ready_in and ack_in in the same DRAIN cycle: the ack is ignored; the byte is released only by an ack seen in WAIT_ACK.
- busy_out = (state != IDLE).

Decomposition:
- Package deser_arb_pkg holds:
  - arb_state_t enum {IDLE, SHIFT, DRAIN, WAIT_ACK}
  - default constants N_SRC_DEF=4, BITS_PER_WORD_DEF=8, STALL_LIMIT_DEF=255
- Sub-module rr_picker: purely combinational (req vector, pointer) -> (found, index).
- Everything else (FSM, counters, mux, tags) lives in deser_input_arbiter.

Test Plan:
- Single source: req_in=0001, source 0 shifts 8 bits of 0xA5, then ready and ack are driven → grant_out=0001 one cycle after req; exactly 8 deser_write_out pulses; tag_valid_out=1 with src_id_out=0; grant_out=0 after the 8th bit; IDLE after ack.
- Round-robin: req_in=1111 held, 3 bytes completed with acks → grant order 0,1,2; then request on 3 and 0 only → grant 3 then 0.
- Non-owner isolation: source 1 granted; source 2 toggles src_write_in every cycle → no forwarded pulses from source 2; the byte contains only source 1's bits.
- Backpressure: deser_status_in=0 with req_in=0010 → grant_out stays 0 indefinitely; raising status → grant 0010 one cycle later.
- Stall: owner stops after 3 bits for 255 cycles → stall_err_out=1 and stays 1; grant still held; after 5 more bits → DRAIN.
- Reset mid-SHIFT after 4 bits → all outputs 0 immediately; state IDLE; next grant starts from source 0 with count 0.

Source files
------------

// File: rtl/deser_arb_pkg.sv
// Shared types and defaults for the deserializer input arbiter.
package deser_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        DRAIN    = 2'd2,
        WAIT_ACK = 2'd3
    } arb_state_t;

    localparam int unsigned N_SRC_DEF         = 4;
    localparam int unsigned BITS_PER_WORD_DEF = 8;
    localparam int unsigned STALL_LIMIT_DEF   = 255;

    // Counter width that never collapses to zero bits.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin search: first asserted request at or after ptr, wrapping.
module rr_picker
    import deser_arb_pkg::*;
#(
    parameter int unsigned N_SRC = N_SRC_DEF,
    parameter int unsigned ID_W  = cnt_width(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             found,
    output logic [ID_W-1:0]  index
);

    // Scan N_SRC positions starting at ptr; the first hit wins.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        index = '0;
        idx   = 0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            idx = (32'(ptr) + k) % N_SRC;
            if (!found && req[ID_W'(idx)]) begin
                found = 1'b1;
                index = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/deser_input_arbiter.sv
// Shares one bit-serial deserializer between N_SRC serial sources, one byte per grant.
module deser_input_arbiter
    import deser_arb_pkg::*;
#(
    parameter int unsigned N_SRC         = N_SRC_DEF,
    parameter int unsigned BITS_PER_WORD = BITS_PER_WORD_DEF,
    parameter int unsigned STALL_LIMIT   = STALL_LIMIT_DEF,
    parameter int unsigned ID_W          = cnt_width(N_SRC)
) (
    input  logic              clock_100KHZ,
    input  logic              reset,
    input  logic [N_SRC-1:0]  req_in,
    input  logic [N_SRC-1:0]  src_data_in,
    input  logic [N_SRC-1:0]  src_write_in,
    output logic [N_SRC-1:0]  grant_out,
    input  logic              deser_status_in,
    input  logic              deser_ready_in,
    input  logic              ack_in,
    output logic              deser_data_out,
    output logic              deser_write_out,
    output logic [ID_W-1:0]   src_id_out,
    output logic              tag_valid_out,
    output logic              busy_out,
    output logic              stall_err_out
);

    localparam int unsigned CNT_W   = cnt_width(BITS_PER_WORD);
    localparam int unsigned STALL_W = cnt_width(STALL_LIMIT + 1);

    arb_state_t         state, state_nx;
    logic [ID_W-1:0]    rr_ptr, rr_ptr_nx;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_nx;
    logic [STALL_W-1:0] stall_cnt, stall_cnt_nx;
    logic [N_SRC-1:0]   grant_nx;
    logic [ID_W-1:0]    src_id_nx;
    logic               tag_valid_nx;
    logic               stall_err_nx;
    logic               busy_nx;

    logic               pick_found;
    logic [ID_W-1:0]    pick_idx;
    logic               fwd_write;
    logic               last_bit;
    logic               grant_now;
    logic [ID_W-1:0]    owner_next;

    rr_picker #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_rr_picker (
        .req   (req_in),
        .ptr   (rr_ptr),
        .found (pick_found),
        .index (pick_idx)
    );

    // Owner strobe forwarding; src_id_out holds the owner while in SHIFT.
    always_comb begin
        fwd_write = 1'b0;
        if (state == SHIFT) begin
            fwd_write = src_write_in[src_id_out] & deser_status_in;
        end
    end

    assign deser_write_out = fwd_write;
    assign deser_data_out  = fwd_write & src_data_in[src_id_out];

    assign last_bit   = fwd_write && (bit_cnt == CNT_W'(BITS_PER_WORD - 1));
    assign grant_now  = deser_status_in && pick_found;
    assign owner_next = (src_id_out == ID_W'(N_SRC - 1)) ? '0 : src_id_out + ID_W'(1);

    // State register.
    always_ff @(posedge clock_100KHZ or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (grant_now)      state_nx = SHIFT;
            SHIFT:    if (last_bit)       state_nx = DRAIN;
            DRAIN:    if (deser_ready_in) state_nx = WAIT_ACK;
            WAIT_ACK: if (ack_in)         state_nx = IDLE;
            default:                      state_nx = IDLE;
        endcase
    end

    // Next values of counters, pointer and registered outputs.
    always_comb begin
        grant_nx     = grant_out;
        src_id_nx    = src_id_out;
        tag_valid_nx = tag_valid_out;
        stall_err_nx = stall_err_out;
        rr_ptr_nx    = rr_ptr;
        bit_cnt_nx   = bit_cnt;
        stall_cnt_nx = stall_cnt;
        busy_nx      = (state_nx != IDLE);
        case (state)
            IDLE: begin
                stall_cnt_nx = '0;
                if (grant_now) begin
                    grant_nx           = '0;
                    grant_nx[pick_idx] = 1'b1;
                    src_id_nx          = pick_idx;
                    bit_cnt_nx         = '0;
                end
            end
            SHIFT: begin
                if (fwd_write) begin
                    stall_cnt_nx = '0;
                    if (last_bit) begin
                        grant_nx   = '0;
                        bit_cnt_nx = '0;
                    end else begin
                        bit_cnt_nx = bit_cnt + CNT_W'(1);
                    end
                end else begin
                    // Saturating idle count; the flag is sticky and the grant is kept.
                    if (stall_cnt != STALL_W'(STALL_LIMIT)) begin
                        stall_cnt_nx = stall_cnt + STALL_W'(1);
                    end
                    if (stall_cnt == STALL_W'(STALL_LIMIT - 1)) begin
                        stall_err_nx = 1'b1;
                    end
                end
            end
            DRAIN: begin
                stall_cnt_nx = '0;
                if (deser_ready_in) begin
                    tag_valid_nx = 1'b1;
                end
            end
            WAIT_ACK: begin
                stall_cnt_nx = '0;
                if (ack_in) begin
                    tag_valid_nx = 1'b0;
                    rr_ptr_nx    = owner_next;
                end
            end
            default: begin
                stall_cnt_nx = '0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clock_100KHZ or posedge reset) begin
        if (reset) begin
            grant_out     <= '0;
            src_id_out    <= '0;
            tag_valid_out <= 1'b0;
            stall_err_out <= 1'b0;
            busy_out      <= 1'b0;
            rr_ptr        <= '0;
            bit_cnt       <= '0;
            stall_cnt     <= '0;
        end else begin
            grant_out     <= grant_nx;
            src_id_out    <= src_id_nx;
            tag_valid_out <= tag_valid_nx;
            stall_err_out <= stall_err_nx;
            busy_out      <= busy_nx;
            rr_ptr        <= rr_ptr_nx;
            bit_cnt       <= bit_cnt_nx;
            stall_cnt     <= stall_cnt_nx;
        end
    end

endmodule

// File: tb/tb_deser_input_arbiter.sv
// Self-checking bench for deser_input_arbiter: bytes scoreboarded by owner id and content.
module tb_deser_input_arbiter;

    logic       clock_100KHZ = 1'b0;
    logic       reset;
    logic [3:0] req, sdata, swrite;
    logic [3:0] grant_out;
    logic       status, ready, ack;
    logic       deser_data_out, deser_write_out;
    logic [1:0] src_id_out;
    logic       tag_valid_out, busy_out, stall_err_out;

    deser_input_arbiter #(
        .N_SRC         (4),
        .BITS_PER_WORD (8),
        .STALL_LIMIT   (255)
    ) dut (
        .clock_100KHZ    (clock_100KHZ),
        .reset           (reset),
        .req_in          (req),
        .src_data_in     (sdata),
        .src_write_in    (swrite),
        .grant_out       (grant_out),
        .deser_status_in (status),
        .deser_ready_in  (ready),
        .ack_in          (ack),
        .deser_data_out  (deser_data_out),
        .deser_write_out (deser_write_out),
        .src_id_out      (src_id_out),
        .tag_valid_out   (tag_valid_out),
        .busy_out        (busy_out),
        .stall_err_out   (stall_err_out)
    );

    always #5 clock_100KHZ = ~clock_100KHZ;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];

    function automatic logic [3:0] oh(input int i);
        logic [3:0] one;
        one = 4'd1;
        return one << i;
    endfunction

    // Deserializer model: collects forwarded bits MSB first, checks tagged bytes.
    logic [7:0] shreg;
    int         nbits;
    logic       tag_prev;
    exp_t       e;

    always @(negedge clock_100KHZ) begin
        if (reset) begin
            shreg    = '0;
            nbits    = 0;
            tag_prev = 1'b0;
        end else begin
            if (deser_write_out) begin
                shreg = {shreg[6:0], deser_data_out};
                nbits++;
            end else begin
                check("data_idle", 32'(deser_data_out), 32'd0);
            end
            if (tag_valid_out && !tag_prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_tag", 32'(tag_valid_out), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("tag_id", 32'(src_id_out), 32'(e.id));
                    check("byte_data", 32'(shreg), 32'(e.data));
                    check("bit_count", 32'(nbits), 32'd8);
                end
                shreg = '0;
                nbits = 0;
            end
            tag_prev = tag_valid_out;
        end
    end

    task automatic tick();
        @(posedge clock_100KHZ);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_grant(input int src);
        int k;
        k = 0;
        while (grant_out == 4'd0 && k < 20) begin
            tick();
            k++;
        end
        check("grant", 32'(grant_out), 32'(oh(src)));
        check("src_id", 32'(src_id_out), 32'(src));
    endtask

    // Drive bits first..last of data from src, optionally with idle gaps and source-2 noise.
    task automatic send_bits(input int src, input logic [7:0] data, input int first,
                             input int last, input bit gaps, input bit noise);
        for (int i = first; i <= last; i++) begin
            swrite[2'(src)] = 1'b1;
            sdata[2'(src)]  = data[3'(7 - i)];
            if (noise) begin
                swrite[2] = ~swrite[2];
                sdata[2]  = 1'b1;
            end
            tick();
            if (i == 6) check("grant_hold", 32'(grant_out), 32'(oh(src)));
            swrite[2'(src)] = 1'b0;
            sdata[2'(src)]  = 1'b1;
            if (gaps) begin
                if (noise) swrite[2] = ~swrite[2];
                tick();
            end
        end
        swrite = '0;
        sdata  = '0;
    endtask

    task automatic finish_byte(input bit simul);
        int k;
        ready = 1'b1;
        if (simul) ack = 1'b1;
        k = 0;
        tick();
        while (!tag_valid_out && k < 20) begin
            tick();
            k++;
        end
        check("tag_valid", 32'(tag_valid_out), 32'd1);
        ready = 1'b0;
        if (simul) begin
            ack = 1'b0;
            tick();
            check("ack_in_drain_ignored", 32'(tag_valid_out), 32'd1);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("tag_clear", 32'(tag_valid_out), 32'd0);
        check("busy_idle", 32'(busy_out), 32'd0);
    endtask

    task automatic do_byte(input int src, input logic [7:0] data, input bit gaps,
                           input bit noise, input bit simul);
        sb.push_back('{id: 2'(src), data: data});
        wait_grant(src);
        send_bits(src, data, 0, 7, gaps, noise);
        check("grant_drop", 32'(grant_out), 32'd0);
        check("busy_drain", 32'(busy_out), 32'd1);
        finish_byte(simul);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req    = '0;
        sdata  = '0;
        swrite = '0;
        status = 1'b1;
        ready  = 1'b0;
        ack    = 1'b0;
        reset  = 1'b1;
        tick();
        check("rst_grant", 32'(grant_out), 32'd0);
        check("rst_src_id", 32'(src_id_out), 32'd0);
        check("rst_tag", 32'(tag_valid_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_stall", 32'(stall_err_out), 32'd0);
        check("rst_write", 32'(deser_write_out), 32'd0);
        reset = 1'b0;
        tick();

        // Single source, one-cycle grant latency.
        req = 4'b0001;
        check("pre_grant", 32'(grant_out), 32'd0);
        tick();
        check("grant_latency", 32'(grant_out), 32'h1);
        do_byte(0, 8'hA5, 1'b0, 1'b0, 1'b0);
        req = 4'b0000;
        tick();

        // Round-robin from a fresh pointer.
        do_reset();
        req = 4'b1111;
        do_byte(0, 8'h11, 1'b0, 1'b0, 1'b0);
        do_byte(1, 8'h22, 1'b0, 1'b0, 1'b0);
        do_byte(2, 8'h33, 1'b0, 1'b0, 1'b1);
        req = 4'b1001;
        do_byte(3, 8'h44, 1'b0, 1'b0, 1'b0);
        do_byte(0, 8'h55, 1'b0, 1'b0, 1'b0);
        req = 4'b0000;
        tick();

        // Non-owner strobes from source 2 must not leak.
        req = 4'b0010;
        do_byte(1, 8'h3C, 1'b1, 1'b1, 1'b0);
        req = 4'b0000;
        tick();

        // Backpressure: no grant while the deserializer cannot accept.
        status = 1'b0;
        req    = 4'b0010;
        repeat (20) tick();
        check("bp_no_grant", 32'(grant_out), 32'd0);
        check("bp_not_busy", 32'(busy_out), 32'd0);
        status = 1'b1;
        tick();
        check("bp_grant_latency", 32'(grant_out), 32'h2);
        do_byte(1, 8'h96, 1'b0, 1'b0, 1'b0);
        req = 4'b0000;
        tick();

        // Stall: owner pauses after 3 bits.
        req = 4'b0001;
        sb.push_back('{id: 2'd0, data: 8'hC3});
        wait_grant(0);
        req = 4'b0000;
        send_bits(0, 8'hC3, 0, 2, 1'b0, 1'b0);
        repeat (200) tick();
        check("stall_not_yet", 32'(stall_err_out), 32'd0);
        repeat (60) tick();
        check("stall_set", 32'(stall_err_out), 32'd1);
        check("stall_grant_kept", 32'(grant_out), 32'h1);
        send_bits(0, 8'hC3, 3, 7, 1'b0, 1'b0);
        check("stall_grant_drop", 32'(grant_out), 32'd0);
        check("stall_busy_drain", 32'(busy_out), 32'd1);
        finish_byte(1'b0);
        check("stall_sticky", 32'(stall_err_out), 32'd1);

        // Reset in the middle of a byte.
        req = 4'b0100;
        wait_grant(2);
        send_bits(2, 8'hF0, 0, 3, 1'b0, 1'b0);
        swrite[2] = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_grant", 32'(grant_out), 32'd0);
        check("mid_rst_busy", 32'(busy_out), 32'd0);
        check("mid_rst_stall", 32'(stall_err_out), 32'd0);
        check("mid_rst_write", 32'(deser_write_out), 32'd0);
        check("mid_rst_src_id", 32'(src_id_out), 32'd0);
        tick();
        tick();
        reset  = 1'b0;
        swrite = '0;
        req    = 4'b0011;
        tick();
        check("post_rst_ptr", 32'(grant_out), 32'h1);
        do_byte(0, 8'h5A, 1'b0, 1'b0, 1'b0);
        req = 4'b0000;
        tick();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
